wide_add_seq: RTL and testbench
===============================

# wide_add_seq

Byte-serial multi-precision add/subtract sequencer built around one instance of the team's 8-bit ripple adder, `adder8bit`. It latches two NBYTES×8-bit operands on a start pulse. It then feeds the adder one byte per cycle, LSB first, carrying through a registered carry flop. It reports the full-width sum, carry-out and signed overflow with a one-cycle done pulse. It gives wide arithmetic to small datapaths without replicating adders.

## Interface
- NBYTES, 4, operand width in bytes (≥2); data width W = 8*NBYTES
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = a+b, 1 = a−b; latched with start
- a  in  W  operand A; latched with start
- b  in  W  operand B; latched with start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; sum/cout/ovf valid
- sum  out  W  result register
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE. Byte index idx is 0..NBYTES−1, width clog2(NBYTES).
- IDLE with start=1:
  - latch a, b, sub
  - idx←0; carry flop←sub
  - sum←0, cout←0, ovf←0
  - go to RUN
- IDLE with start=0: hold all outputs.
- RUN, each cycle, drive the adder with:
  - A = a_l[8*idx+:8]
  - B = b_l[8*idx+:8] ^ {8{sub_l}}
  - Cin = carry flop
- RUN, each cycle, on the clock edge:
  - sum[8*idx+:8]←adder Sum
  - carry flop←adder Cout
  - idx←idx+1
- RUN, when idx = NBYTES−1:
  - cout←adder Cout
  - ovf←(A[7]==B[7]) && (Sum[7]!=A[7]), using the effective (possibly inverted) B byte
  - go to DONE
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Results persist: sum, cout and ovf hold their values until the next accepted start or rst.
- Width rules:
  - sum is modulo 2^W
  - cout is bit W of a + (sub ? ~b : b) + sub
  - no saturation
- start is ignored in RUN and DONE. It is not queued; start high in the DONE cycle is ignored.
- Operand changes are ignored after acceptance, because operands are held in internal registers.
- rst in any state, on the next edge:
  - state←IDLE, idx←0, carry flop←0
  - sum←0, cout←0, ovf←0, busy=0, done=0
  - rst overrides a simultaneous start.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0.
- busy and done are decoded from registered state only. They are not combinational from start.
- Sequence for start sampled at edge k:
  - busy=1 from k+1
  - bytes 0..NBYTES−1 are written at edges k+1..k+NBYTES
  - done=1 and results valid in the cycle after edge k+NBYTES
  - busy=0 after edge k+NBYTES+1
- Latency: start to done is NBYTES+1 cycles.
- Throughput: one operation per NBYTES+2 cycles. The earliest next start is the first IDLE cycle after done.
- While busy, sum shows partially written bytes and is not valid. Consumers sample only on done.
- The critical path is one adder8bit ripple plus the byte mux. No combinational path exists from inputs to outputs.

## Test plan
All scenarios use NBYTES=4.
1. a=0x000000FF, b=0x00000001, sub=0 -> sum=0x00000100, cout=0, ovf=0. done exactly 5 cycles after the start cycle; busy high for 5 cycles.
2. a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, cout=1, ovf=0. a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1.
3. sub=1 cases:
   - a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0
   - a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1
   - a=b=0x12345678 -> sum=0, cout=1, ovf=0
4. Hold start=1 continuously while changing a and b during RUN -> the first result uses the latched operands. Start in the DONE cycle is ignored. The next op is accepted in the following IDLE cycle, with done 6 cycles after the previous done.
5. Assert rst for one cycle while idx=2 of a run -> the next cycle shows busy=0, done=0, sum=0, cout=0, ovf=0. A following start with 0x01010101+0x01010101 completes with sum=0x02020202, unaffected by the stale carry.
6. Randomized 1000 ops, both sub values -> sum, cout and ovf match a W+1-bit reference model at every done. done never asserts without a preceding accepted start.

Source files
------------

// File: rtl/wide_add_seq_if.sv
// Operand/result bundle for the byte-serial wide adder.
// The master issues operations; the slave (the sequencer) returns results.
interface wide_add_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/wide_add_seq.sv
// Byte-serial multi-precision add/subtract: one 8-bit adder walks the operands
// LSB first through a registered carry, then pulses done with sum/cout/ovf.
module adder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module wide_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic           clk,
  input  logic           rst,
  wide_add_seq_if.slave  bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic          sub_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          ovf_q;
  logic          busy_q;
  logic          done_q;

  logic [7:0] a_bytes [NBYTES];
  logic [7:0] b_bytes [NBYTES];
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_cout;

  // Byte lanes of the latched operands; subtraction inverts B and seeds carry with 1.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign a_bytes[gi] = a_q[8*gi +: 8];
    assign b_bytes[gi] = b_q[8*gi +: 8] ^ {8{sub_q}};
  end

  assign add_a = a_bytes[idx_q];
  assign add_b = b_bytes[idx_q];

  adder8bit u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.sub;
            idx_q   <= '0;
            carry_q <= bus.sub;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[8*idx_q +: 8] <= add_sum;
          carry_q             <= add_cout;
          idx_q               <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            // Signed overflow judged on the top byte with the effective B operand.
            cout_q  <= add_cout;
            ovf_q   <= (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed cases plus 1000 random ops
// compared every cycle against an arithmetic reference model.
module tb_wide_add_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wide_add_seq_if #(.NBYTES(NB)) bus();

  wide_add_seq #(.NBYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model state: cycles remaining in the current operation and held results.
  int           cnt = 0;
  logic [W-1:0] e_sum = '0;
  logic         e_cout = 1'b0;
  logic         e_ovf = 1'b0;

  function automatic logic [W:0] ref_full(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
    longint sx, sy, r, lim;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    r   = s ? (sx - sy) : (sx + sy);
    lim = longint'(1) <<< (W - 1);
    return (r >= lim) || (r < -lim);
  endfunction

  always @(posedge clk) begin : model
    logic [W:0] t;
    if (rst) begin
      cnt    <= 0;
      e_sum  <= '0;
      e_cout <= 1'b0;
      e_ovf  <= 1'b0;
    end else if (cnt == 0) begin
      if (bus.start) begin
        t = ref_full(bus.a, bus.b, bus.sub);
        cnt    <= NB + 1;
        e_sum  <= t[W-1:0];
        e_cout <= t[W];
        e_ovf  <= ref_ovf(bus.a, bus.b, bus.sub);
      end
    end else begin
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(bus.busy), 64'(cnt != 0));
      chk("done", 64'(bus.done), 64'(cnt == 1));
      if (cnt == 0 || cnt == 1) begin
        chk("sum",  64'(bus.sum),  64'(e_sum));
        chk("cout", 64'(bus.cout), 64'(e_cout));
        chk("ovf",  64'(bus.ovf),  64'(e_ovf));
      end
    end
  end

  task automatic wait_idle(input string nm);
    int guard;
    guard = 0;
    while (cnt != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL %s_idle_timeout got=busy exp=idle", nm);
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input bit lit, input logic [W-1:0] xs, input logic xc,
                        input logic xo, input string nm);
    int lat, bcnt;
    logic [W:0] mref;
    wait_idle(nm);
    bus.a = av; bus.b = bv; bus.sub = sv; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat  = 1;
    bcnt = int'(bus.busy);
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
      bcnt += int'(bus.busy);
    end
    chk({nm, "_done_latency"}, 64'(lat), 64'(NB + 1));
    chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(NB + 1));
    if (lit) begin
      chk({nm, "_sum"},  64'(bus.sum),  64'(xs));
      chk({nm, "_cout"}, 64'(bus.cout), 64'(xc));
      chk({nm, "_ovf"},  64'(bus.ovf),  64'(xo));
      mref = ref_full(av, bv, sv);
      chk({nm, "_model_sum"},  64'(mref[W-1:0]), 64'(xs));
      chk({nm, "_model_cout"}, 64'(mref[W]),     64'(xc));
      chk({nm, "_model_ovf"},  64'(ref_ovf(av, bv, sv)), 64'(xo));
    end
    $display("op %s a=%h b=%h sub=%0d sum=%h cout=%0d ovf=%0d",
             nm, av, bv, sv, bus.sum, bus.cout, bus.ovf);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2;
    logic [W-1:0] ra, rb;
    rst = 1'b1; bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_sum",  64'(bus.sum),  64'd0);
    chk("reset_cout", 64'(bus.cout), 64'd0);
    chk("reset_ovf",  64'(bus.ovf),  64'd0);

    // Directed arithmetic cases with hand-computed results.
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1, 32'h00000100, 1'b0, 1'b0, "add_carry_chain");
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1, 32'h00000000, 1'b1, 1'b0, "add_wrap");
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1, 32'h80000000, 1'b0, 1'b1, "add_ovf");
    run_op(32'h00000005, 32'h00000007, 1'b1, 1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_borrow");
    run_op(32'h80000000, 32'h00000001, 1'b1, 1, 32'h7FFFFFFF, 1'b1, 1'b1, "sub_ovf");
    run_op(32'h12345678, 32'h12345678, 1'b1, 1, 32'h00000000, 1'b1, 1'b0, "sub_equal");

    // start held high with operands changing during the run.
    wait_idle("hold");
    bus.a = 32'h11111111; bus.b = 32'h22222222; bus.sub = 1'b0; bus.start = 1'b1;
    d1 = -1; d2 = -1;
    for (int n = 1; n <= 20 && d2 < 0; n++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = n;
          chk("hold_first_sum", 64'(bus.sum), 64'h33333333);
        end else begin
          d2 = n;
          bus.start = 1'b0;
        end
      end
      if (d2 < 0) begin
        bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    chk("hold_first_done", 64'(d1), 64'(NB + 1));
    chk("hold_done_spacing", 64'(d2 - d1), 64'(NB + 2));
    $display("op hold first_done=%0d second_done=%0d", d1, d2);
    @(negedge clk);

    // Reset in the middle of a run (idx=2), leaving a stale carry behind.
    wait_idle("midrst");
    bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_sum",  64'(bus.sum),  64'd0);
    chk("midrst_cout", 64'(bus.cout), 64'd0);
    chk("midrst_ovf",  64'(bus.ovf),  64'd0);
    $display("op midrst busy=%0d sum=%h", bus.busy, bus.sum);
    run_op(32'h01010101, 32'h01010101, 1'b0, 1, 32'h02020202, 1'b0, 1'b0, "after_rst");

    // Reset wins over a simultaneous start.
    bus.a = 32'h1; bus.b = 32'h1; bus.start = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b0;
    chk("rst_over_start_busy", 64'(bus.busy), 64'd0);
    $display("op rst_over_start busy=%0d", bus.busy);

    // Randomized operations with occasional corner operands and idle gaps.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFFFFFF;
        1: ra = 32'h80000000;
        2: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h00000001;
        1: rb = 32'h80000000;
        2: rb = ra;
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom), 0, '0, 1'b0, 1'b0, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
